decode_64: RTL and testbench

- Y86-64 pipeline decode stage, directly downstream of the fetch stage; consumes its f_* outputs.
- Holds the D pipeline register with stall/bubble control.
- Contains the 15x64 register file, written from writeback.
- Computes srcA/srcB/dstE/dstM, resolves valA/valB with forwarding, and flags load/use hazards for pipeline control.

---
 rtl/decode_64_if.sv | 28 ++
 rtl/decode_64.sv | 91 +++++++++
 tb/tb_decode_64.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/decode_64_if.sv
// decode_64_if: fetch-to-decode bus plus forwarding, control and decode results
interface decode_64_if;
    logic [3:0]  f_icode, f_ifun, f_rA, f_rB, f_stat;
    logic [63:0] f_valC, f_valP;
    logic        D_stall, D_bubble;
    logic [3:0]  E_icode, E_dstM, e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
    logic [63:0] e_valE, M_valE, m_valM, W_valE, W_valM;
    logic [3:0]  D_icode, D_ifun, D_stat;
    logic [63:0] D_valC, D_valP;
    logic [3:0]  d_srcA, d_srcB, d_dstE, d_dstM;
    logic [63:0] d_valA, d_valB;
    logic        load_use;

    modport master (
        output f_icode, f_ifun, f_rA, f_rB, f_stat, f_valC, f_valP, D_stall, D_bubble,
               E_icode, E_dstM, e_dstE, M_dstE, M_dstM, W_dstE, W_dstM,
               e_valE, M_valE, m_valM, W_valE, W_valM,
        input  D_icode, D_ifun, D_stat, D_valC, D_valP, d_srcA, d_srcB, d_dstE, d_dstM,
               d_valA, d_valB, load_use
    );
    modport slave (
        input  f_icode, f_ifun, f_rA, f_rB, f_stat, f_valC, f_valP, D_stall, D_bubble,
               E_icode, E_dstM, e_dstE, M_dstE, M_dstM, W_dstE, W_dstM,
               e_valE, M_valE, m_valM, W_valE, W_valM,
        output D_icode, D_ifun, D_stat, D_valC, D_valP, d_srcA, d_srcB, d_dstE, d_dstM,
               d_valA, d_valB, load_use
    );
endinterface

// File: rtl/decode_64.sv
// decode_64: Y86-64 decode stage; define DECODE_FWD_EN for full bypassing, else load_use stalls on any in-flight write
module decode_64 #(
    parameter int         NREG   = 15,
    parameter logic [3:0] RSP_ID = 4'd4
) (
    input logic clk,
    input logic rst_n,
    decode_64_if.slave bus
);
    localparam logic [3:0] RNONE = 4'hF;
    logic [3:0]  icode, ifun, stat, ra, rb, src_a, src_b, dst_e, dst_m;
    logic [63:0] valc, valp, val_a, val_b;
    logic [63:0] regs [NREG];
    logic        lu_load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {icode, ifun, ra, rb, stat} <= {4'h1, 4'h0, RNONE, RNONE, 4'b0001};
            {valc, valp} <= '0;
        end else if (bus.D_bubble) begin
            {icode, ifun, ra, rb, stat} <= {4'h1, 4'h0, RNONE, RNONE, 4'b0001};
            {valc, valp} <= '0;
        end else if (!bus.D_stall) begin
            {icode, ifun, ra, rb, stat} <= {bus.f_icode, bus.f_ifun, bus.f_rA, bus.f_rB, bus.f_stat};
            {valc, valp} <= {bus.f_valC, bus.f_valP};
        end
    end

    // valM write follows valE so it wins when both target the same register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            if (bus.W_dstE != RNONE) regs[bus.W_dstE] <= bus.W_valE;
            if (bus.W_dstM != RNONE) regs[bus.W_dstM] <= bus.W_valM;
        end
    end

    always_comb begin
        src_a = (icode == 4'h2 || icode == 4'h4 || icode == 4'h6 || icode == 4'hA) ? ra :
                (icode == 4'h9 || icode == 4'hB) ? RSP_ID : RNONE;
        src_b = (icode == 4'h4 || icode == 4'h5 || icode == 4'h6) ? rb :
                (icode >= 4'h8 && icode <= 4'hB) ? RSP_ID : RNONE;
        dst_e = (icode == 4'h2 || icode == 4'h3 || icode == 4'h6) ? rb :
                (icode >= 4'h8 && icode <= 4'hB) ? RSP_ID : RNONE;
        dst_m = (icode == 4'h5 || icode == 4'hB) ? ra : RNONE;
    end

    function automatic logic [63:0] rf(input logic [3:0] src);
        return (src == RNONE) ? '0 : regs[src];
    endfunction

    function automatic logic [63:0] fwd(input logic [3:0] src);
        return (src == RNONE)       ? '0 :
               (src == bus.e_dstE)  ? bus.e_valE :
               (src == bus.M_dstM)  ? bus.m_valM :
               (src == bus.M_dstE)  ? bus.M_valE :
               (src == bus.W_dstM)  ? bus.W_valM :
               (src == bus.W_dstE)  ? bus.W_valE : rf(src);
    endfunction

    function automatic logic busy(input logic [3:0] src);
        return src != RNONE && (src == bus.e_dstE || src == bus.M_dstE || src == bus.M_dstM ||
                                src == bus.W_dstE || src == bus.W_dstM);
    endfunction

    assign lu_load = (bus.E_icode == 4'h5 || bus.E_icode == 4'hB) && bus.E_dstM != RNONE &&
                     (bus.E_dstM == src_a || bus.E_dstM == src_b);

`ifdef DECODE_FWD_EN
    assign val_a        = (icode == 4'h7 || icode == 4'h8) ? valp : fwd(src_a);
    assign val_b        = fwd(src_b);
    assign bus.load_use = lu_load;
`else
    assign val_a        = (icode == 4'h7 || icode == 4'h8) ? valp : rf(src_a);
    assign val_b        = rf(src_b);
    assign bus.load_use = lu_load || busy(src_a) || busy(src_b);
`endif

    assign bus.D_icode = icode;
    assign bus.D_ifun  = ifun;
    assign bus.D_stat  = stat;
    assign bus.D_valC  = valc;
    assign bus.D_valP  = valp;
    assign bus.d_srcA  = src_a;
    assign bus.d_srcB  = src_b;
    assign bus.d_dstE  = dst_e;
    assign bus.d_dstM  = dst_m;
    assign bus.d_valA  = val_a;
    assign bus.d_valB  = val_b;
endmodule

// File: tb/tb_decode_64.sv
// tb_decode_64: directed scoreboard bench for decode_64
module tb_decode_64;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    decode_64_if bus();
    decode_64 dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct { string tag; logic [63:0] val; } exp_t;
    exp_t sb[$];
    int n_chk = 0;
    int n_fail = 0;
`ifdef DECODE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    task automatic push(input string tag, input logic [63:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic chk(input logic [63:0] obs);
        exp_t e;
        n_chk++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty: observed %0h required nothing", obs);
            return;
        end
        e = sb.pop_front();
        assert (obs === e.val) else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", e.tag, obs, e.val);
        end
    endtask

    task automatic fetch(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] ra,
                         input logic [3:0] rb, input logic [63:0] vc, input logic [63:0] vp,
                         input logic [3:0] st);
        bus.f_icode = ic; bus.f_ifun = fn; bus.f_rA = ra; bus.f_rB = rb;
        bus.f_valC = vc; bus.f_valP = vp; bus.f_stat = st;
    endtask

    task automatic idle();
        fetch(4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0, 4'b0001);
        bus.D_stall = 1'b0; bus.D_bubble = 1'b0;
        bus.E_icode = 4'h1; bus.E_dstM = 4'hF; bus.e_dstE = 4'hF;
        bus.M_dstE = 4'hF; bus.M_dstM = 4'hF; bus.W_dstE = 4'hF; bus.W_dstM = 4'hF;
        bus.e_valE = '0; bus.M_valE = '0; bus.m_valM = '0; bus.W_valE = '0; bus.W_valM = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        #12;
        push("rst_D_icode", 64'h1); push("rst_D_stat", 64'h1);
        chk(bus.D_icode); chk(bus.D_stat);
        #1 rst_n = 1'b1;
        step(); #1;
        push("idle_D_icode", 64'h1); push("idle_D_stat", 64'h1);
        push("idle_valA", 64'h0); push("idle_valB", 64'h0);
        push("idle_srcA", 64'hF); push("idle_srcB", 64'hF);
        push("idle_dstE", 64'hF); push("idle_dstM", 64'hF); push("idle_load_use", 64'h0);
        chk(bus.D_icode); chk(bus.D_stat); chk(bus.d_valA); chk(bus.d_valB);
        chk(bus.d_srcA); chk(bus.d_srcB); chk(bus.d_dstE); chk(bus.d_dstM); chk(bus.load_use);

        // irmovq $0x10, r2
        fetch(4'h3, 4'h0, 4'hF, 4'h2, 64'h10, 64'h0A, 4'b0001);
        push("irm_D_icode", 64'h3); push("irm_D_valC", 64'h10); push("irm_D_valP", 64'h0A);
        push("irm_dstE", 64'h2); push("irm_srcA", 64'hF);
        step(); #1;
        chk(bus.D_icode); chk(bus.D_valC); chk(bus.D_valP); chk(bus.d_dstE); chk(bus.d_srcA);

        // writeback r2 while addq r2,r2 is fetched
        bus.W_dstE = 4'h2; bus.W_valE = 64'h10;
        fetch(4'h6, 4'h0, 4'h2, 4'h2, 64'h0, 64'h0C, 4'b0001);
        push("add_D_icode", 64'h6); push("add_valA", 64'h10); push("add_valB", 64'h10);
        push("add_dstE", 64'h2);
        step(); bus.W_dstE = 4'hF; #1;
        chk(bus.D_icode); chk(bus.d_valA); chk(bus.d_valB); chk(bus.d_dstE);

        // same-cycle write is seen only through forwarding
        bus.D_stall = 1'b1; bus.W_dstE = 4'h2; bus.W_valE = 64'h99; #1;
        push("wb_same_cycle_valA", FWD ? 64'h99 : 64'h10);
        chk(bus.d_valA);
        step(); bus.W_dstE = 4'hF; #1;
        push("wb_after_edge_valA", 64'h99); push("wb_after_edge_valB", 64'h99);
        chk(bus.d_valA); chk(bus.d_valB);

        // execute beats memory, memory valM beats writeback
        bus.e_dstE = 4'h2; bus.e_valE = 64'h9; bus.M_dstE = 4'h2; bus.M_valE = 64'h7; #1;
        push("prio_e_valA", FWD ? 64'h9 : 64'h99); push("prio_e_load_use", FWD ? 64'h0 : 64'h1);
        chk(bus.d_valA); chk(bus.load_use);
        bus.e_dstE = 4'hF; #1;
        push("prio_M_valA", FWD ? 64'h7 : 64'h99);
        chk(bus.d_valA);
        bus.M_dstE = 4'hF; bus.M_dstM = 4'h2; bus.m_valM = 64'h55;
        bus.W_dstM = 4'h2; bus.W_valM = 64'h66; #1;
        push("prio_mvalM_valB", FWD ? 64'h55 : 64'h99);
        chk(bus.d_valB);
        bus.M_dstM = 4'hF; bus.W_dstM = 4'hF;

        // load/use: mrmovq into r3 in execute, addq r3,r1 in decode
        bus.D_stall = 1'b0;
        fetch(4'h6, 4'h0, 4'h3, 4'h1, 64'h0, 64'h20, 4'b0001);
        step();
        bus.E_icode = 4'h5; bus.E_dstM = 4'h3; #1;
        push("lu_mrmov", 64'h1); chk(bus.load_use);
        bus.E_icode = 4'h2; #1;
        push("lu_not_load", 64'h0); chk(bus.load_use);
        bus.E_icode = 4'h5;
        bus.D_stall = 1'b1;
        fetch(4'h3, 4'h0, 4'hF, 4'h5, 64'h77, 64'h2A, 4'b0001);
        push("stall_D_icode", 64'h6); push("stall_D_valP", 64'h20);
        step(); #1;
        chk(bus.D_icode); chk(bus.D_valP);
        bus.D_bubble = 1'b1;
        push("bubble_D_icode", 64'h1); push("bubble_D_valP", 64'h0);
        push("bubble_D_stat", 64'h1); push("bubble_load_use", 64'h0);
        step(); #1;
        chk(bus.D_icode); chk(bus.D_valP); chk(bus.D_stat); chk(bus.load_use);
        bus.D_bubble = 1'b0; bus.D_stall = 1'b0; bus.E_icode = 4'h1; bus.E_dstM = 4'hF;

        // invalid icode keeps its status, no sources or destinations
        fetch(4'hC, 4'h0, 4'h3, 4'h4, 64'h0, 64'h30, 4'b1000);
        push("inv_D_icode", 64'hC); push("inv_D_stat", 64'h8);
        push("inv_srcA", 64'hF); push("inv_srcB", 64'hF); push("inv_dstE", 64'hF); push("inv_dstM", 64'hF);
        step(); #1;
        chk(bus.D_icode); chk(bus.D_stat); chk(bus.d_srcA); chk(bus.d_srcB); chk(bus.d_dstE); chk(bus.d_dstM);

        // popq %rsp, then both writeback ports hit r4 on one edge
        fetch(4'hB, 4'h0, 4'h4, 4'hF, 64'h0, 64'h32, 4'b0001);
        push("pop_dstM", 64'h4); push("pop_dstE", 64'h4); push("pop_srcA", 64'h4); push("pop_srcB", 64'h4);
        step(); #1;
        chk(bus.d_dstM); chk(bus.d_dstE); chk(bus.d_srcA); chk(bus.d_srcB);
        bus.W_dstE = 4'h4; bus.W_valE = 64'h108; bus.W_dstM = 4'h4; bus.W_valM = 64'hAA;
        fetch(4'h8, 4'h0, 4'hF, 4'hF, 64'h300, 64'h209, 4'b0001);
        push("call_valA", 64'h209); push("call_valB_rsp", 64'hAA);
        push("call_srcB", 64'h4); push("call_dstE", 64'h4);
        step(); bus.W_dstE = 4'hF; bus.W_dstM = 4'hF; #1;
        chk(bus.d_valA); chk(bus.d_valB); chk(bus.d_srcB); chk(bus.d_dstE);

        // asynchronous reset between edges
        #2 rst_n = 1'b0;
        push("arst_D_icode", 64'h1); push("arst_D_valP", 64'h0); push("arst_D_stat", 64'h1);
        #1;
        chk(bus.D_icode); chk(bus.D_valP); chk(bus.D_stat);
        #1 rst_n = 1'b1;
        idle();
        fetch(4'h6, 4'h0, 4'h4, 4'h2, 64'h0, 64'h40, 4'b0001);
        push("arst_r4_cleared", 64'h0); push("arst_r2_cleared", 64'h0);
        step(); #1;
        chk(bus.d_valA); chk(bus.d_valB);

        if (sb.size() != 0) begin
            n_chk++; n_fail++;
            $error("FAIL scoreboard_leftover: observed %0d entries required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
